// File: rtl/sw_pkg.sv
// Shared Smith-Waterman definitions: pointer codes, alignment-op codes and
// the traceback FSM state encoding. The PE array drives its pointer outputs
// with the same PTR_* codes that the traceback engine decodes.
package sw_pkg;

    // Direction-pointer codes stored in the pointer memory.
    localparam logic [2:0] PTR_UP   = 3'd1;   // row-1
    localparam logic [2:0] PTR_LEFT = 3'd2;   // col-1
    localparam logic [2:0] PTR_DIAG = 3'd3;   // row-1, col-1
    localparam logic [2:0] PTR_STOP = 3'b111; // zero score, path ends here

    // Alignment operations emitted on the op stream.
    typedef enum logic [1:0] {
        OP_DIAG = 2'd0,
        OP_UP   = 2'd1,
        OP_LEFT = 2'd2
    } op_code_e;

    // Traceback FSM states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_WAIT = 3'd2,
        ST_EMIT = 3'd3,
        ST_FIN  = 3'd4
    } trace_state_e;

    function automatic op_code_e ptr_to_op(input logic [2:0] code);
        case (code)
            PTR_UP:   return OP_UP;
            PTR_LEFT: return OP_LEFT;
            default:  return OP_DIAG;
        endcase
    endfunction

    function automatic logic ptr_moves_row(input logic [2:0] code);
        return (code == PTR_UP) || (code == PTR_DIAG);
    endfunction

    function automatic logic ptr_moves_col(input logic [2:0] code);
        return (code == PTR_LEFT) || (code == PTR_DIAG);
    endfunction

endpackage

// File: rtl/traceback_engine.sv
// Smith-Waterman traceback engine.
// Walks the external direction-pointer memory from a max-score cell back
// towards the matrix edge, emitting one alignment op per step.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   start, start_row/col  traceback request and starting cell (accepted in IDLE)
//   start_ready           high only in IDLE
//   ptr_rd_en, ptr_row/col pointer-memory read strobe and address
//   ptr_data              pointer code, valid the cycle after ptr_rd_en
//   op_valid, op_code     op stream (DIAG/UP/LEFT); held until op_ready
//   op_ready              downstream accept
//   done                  one-cycle pulse at the end of a traceback
//   path_len              ops emitted (saturating), stable until next start
//   err                   sticky illegal-pointer flag, cleared on next start
//   dbg_state             current FSM state
//
// Handshake: an op transfers on a rising edge where op_valid and op_ready are
// both high; while op_valid is high and op_ready low, op_code, the read
// address and the path length hold their values.
module traceback_engine
    import sw_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_row,
    input  logic [ADDR_W-1:0] start_col,
    output logic              start_ready,
    output logic              ptr_rd_en,
    output logic [ADDR_W-1:0] ptr_row,
    output logic [ADDR_W-1:0] ptr_col,
    input  logic [2:0]        ptr_data,
    output logic              op_valid,
    output logic [1:0]        op_code,
    input  logic              op_ready,
    output logic              done,
    output logic [LEN_W-1:0]  path_len,
    output logic              err,
    output trace_state_e      dbg_state
);

    trace_state_e      state_q;
    logic [ADDR_W-1:0] cur_row_q;
    logic [ADDR_W-1:0] cur_col_q;
    logic [2:0]        ptr_q;
    logic              rd_en_q;
    logic              op_valid_q;
    op_code_e          op_code_q;
    logic              done_q;
    logic              err_q;
    logic [LEN_W-1:0]  len_q;

    logic              move_ok_d;
    logic              is_stop_d;
    logic [ADDR_W-1:0] row_d;
    logic [ADDR_W-1:0] col_d;
    logic [LEN_W-1:0]  len_d;
    logic              at_edge_d;

    // Decode of the pointer arriving in WAIT. A legal direction that would
    // step off row 0 or col 0 is rejected here and handled like STOP + err.
    always_comb begin
        is_stop_d = (ptr_data == PTR_STOP);
        move_ok_d = 1'b0;
        case (ptr_data)
            PTR_UP:   move_ok_d = (cur_row_q != '0);
            PTR_LEFT: move_ok_d = (cur_col_q != '0);
            PTR_DIAG: move_ok_d = (cur_row_q != '0) && (cur_col_q != '0);
            default:  move_ok_d = 1'b0;
        endcase
    end

    // Next cell and length, applied on the EMIT handshake from the pointer
    // registered in WAIT.
    always_comb begin
        row_d     = ptr_moves_row(ptr_q) ? cur_row_q - ADDR_W'(1) : cur_row_q;
        col_d     = ptr_moves_col(ptr_q) ? cur_col_q - ADDR_W'(1) : cur_col_q;
        len_d     = (&len_q) ? len_q : len_q + LEN_W'(1);
        at_edge_d = (row_d == '0) || (col_d == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cur_row_q  <= '0;
            cur_col_q  <= '0;
            ptr_q      <= '0;
            rd_en_q    <= 1'b0;
            op_valid_q <= 1'b0;
            op_code_q  <= OP_DIAG;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            len_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        cur_row_q <= start_row;
                        cur_col_q <= start_col;
                        len_q     <= '0;
                        err_q     <= 1'b0;
                        rd_en_q   <= 1'b1;
                        state_q   <= ST_READ;
                    end
                end
                ST_READ: begin
                    rd_en_q <= 1'b0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    ptr_q <= ptr_data;
                    if (move_ok_d) begin
                        op_valid_q <= 1'b1;
                        op_code_q  <= ptr_to_op(ptr_data);
                        state_q    <= ST_EMIT;
                    end else begin
                        // STOP ends cleanly; anything else is an error.
                        if (!is_stop_d) begin
                            err_q <= 1'b1;
                        end
                        state_q <= ST_FIN;
                    end
                end
                ST_EMIT: begin
                    if (op_ready) begin
                        op_valid_q <= 1'b0;
                        cur_row_q  <= row_d;
                        cur_col_q  <= col_d;
                        len_q      <= len_d;
                        if (at_edge_d) begin
                            state_q <= ST_FIN;
                        end else begin
                            rd_en_q <= 1'b1;
                            state_q <= ST_READ;
                        end
                    end
                end
                ST_FIN: begin
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign start_ready = (state_q == ST_IDLE);
    assign ptr_rd_en   = rd_en_q;
    assign ptr_row     = cur_row_q;
    assign ptr_col     = cur_col_q;
    assign op_valid    = op_valid_q;
    assign op_code     = op_code_q;
    assign done        = done_q;
    assign path_len    = len_q;
    assign err         = err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_traceback_engine.sv
// Self-checking bench for traceback_engine. A behavioural pointer-memory
// model answers reads; a reference walk over the same memory predicts the op
// sequence, read addresses, path length, error flag and done latency.
module tb_traceback_engine;
    import sw_pkg::*;

    localparam int ADDR_W  = 6;
    localparam int LEN_W   = 5;  // narrow so long paths reach saturation
    localparam int LEN_MAX = (1 << LEN_W) - 1;

    logic              clk;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] start_row;
    logic [ADDR_W-1:0] start_col;
    logic              start_ready;
    logic              ptr_rd_en;
    logic [ADDR_W-1:0] ptr_row;
    logic [ADDR_W-1:0] ptr_col;
    logic [2:0]        ptr_data;
    logic              op_valid;
    logic [1:0]        op_code;
    logic              op_ready;
    logic              done;
    logic [LEN_W-1:0]  path_len;
    logic              err;
    trace_state_e      dbg_state;

    traceback_engine #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_row  (start_row),
        .start_col  (start_col),
        .start_ready(start_ready),
        .ptr_rd_en  (ptr_rd_en),
        .ptr_row    (ptr_row),
        .ptr_col    (ptr_col),
        .ptr_data   (ptr_data),
        .op_valid   (op_valid),
        .op_code    (op_code),
        .op_ready   (op_ready),
        .done       (done),
        .path_len   (path_len),
        .err        (err),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int checks   = 0;
    int failures = 0;

    logic [2:0]  mem [64][64];
    logic [1:0]  exp_q[$];
    logic [11:0] addr_q[$];
    int exp_len, exp_err, exp_reads, exp_ops;
    int cyc, done_cnt, done_cyc, stalls, reads_seen;
    int ready_mode;  // 0: op_ready driven by scenario, 1: random

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference walk ----------------
    task automatic model(input int sr, input int sc);
        int r;
        int c;
        int dr;
        int dc;
        logic [2:0] code;
        r = sr;
        c = sc;
        exp_q.delete();
        addr_q.delete();
        exp_len = 0; exp_err = 0; exp_reads = 0; exp_ops = 0;
        while (1) begin
            code = mem[r][c];
            addr_q.push_back(12'((r << 6) | c));
            exp_reads++;
            if (code == 3'b111) break;
            dr = (code == 3'd1 || code == 3'd3) ? 1 : 0;
            dc = (code == 3'd2 || code == 3'd3) ? 1 : 0;
            if (dr == 0 && dc == 0) begin exp_err = 1; break; end
            if ((dr == 1 && r == 0) || (dc == 1 && c == 0)) begin exp_err = 1; break; end
            exp_q.push_back(code == 3'd1 ? 2'd1 : (code == 3'd2 ? 2'd2 : 2'd0));
            exp_ops++;
            if (exp_len < LEN_MAX) exp_len++;
            r -= dr;
            c -= dc;
            if (r == 0 || c == 0) break;
        end
    endtask

    // ---------------- pointer memory model ----------------
    initial begin : mem_model
        logic       rd;
        logic [5:0] ar;
        logic [5:0] ac;
        forever begin
            @(negedge clk);
            rd = ptr_rd_en; ar = ptr_row; ac = ptr_col;
            @(posedge clk);
            #1;
            ptr_data = rd ? mem[ar][ac] : 3'($urandom_range(0, 7));
        end
    end

    // ---------------- random op_ready driver ----------------
    initial begin : ready_drv
        forever begin
            @(posedge clk);
            #2;
            if (ready_mode == 1) op_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic        prev_rd;
        logic        prev_done;
        logic        hold;
        logic [1:0]  hold_code;
        logic [11:0] hold_addr;
        prev_rd = 0; prev_done = 0; hold = 0; hold_code = 0; hold_addr = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                prev_rd = 0; prev_done = 0; hold = 0;
            end else begin
                if (done) begin done_cnt++; done_cyc = cyc; end
                if (prev_done) check("done_one_cycle", done, 0);
                if (ptr_rd_en) begin
                    check("rd_only_in_read", dbg_state == ST_READ, 1);
                    check("rd_single_cycle", prev_rd, 0);
                    reads_seen++;
                    if (addr_q.size() == 0) check("rd_unexpected", ptr_rd_en, 0);
                    else check("rd_addr", {ptr_row, ptr_col}, addr_q.pop_front());
                end
                if (hold) begin
                    check("hold_valid", op_valid, 1);
                    check("hold_code", op_code, hold_code);
                    check("hold_no_rd", ptr_rd_en, 0);
                    check("hold_addr", {ptr_row, ptr_col}, hold_addr);
                end
                if (op_valid && op_ready) begin
                    if (exp_q.size() == 0) check("op_unexpected", op_valid && op_ready, 0);
                    else check("op_code", op_code, exp_q.pop_front());
                end
                if (op_valid && !op_ready) stalls++;
                prev_rd   = ptr_rd_en;
                prev_done = done;
                hold      = op_valid && !op_ready;
                hold_code = op_code;
                hold_addr = {ptr_row, ptr_col};
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic fill_mem(input logic [2:0] code);
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 64; c++)
                mem[r][c] = code;
    endtask

    task automatic fill_random();
        for (int r = 0; r < 64; r++) begin
            for (int c = 0; c < 64; c++) begin
                int v;
                v = $urandom_range(0, 99);
                if (v < 25)      mem[r][c] = 3'd1;
                else if (v < 50) mem[r][c] = 3'd2;
                else if (v < 97) mem[r][c] = 3'd3;
                else if (v < 99) mem[r][c] = 3'b111;
                else mem[r][c] = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(4, 6));
            end
        end
    endtask

    task automatic launch(input int r, input int c);
        int n;
        n = 0;
        while (!start_ready && n < 500) begin @(posedge clk); #1; n++; end
        if (n >= 500) check("start_ready_timeout", start_ready, 1);
        start_row = ADDR_W'(r);
        start_col = ADDR_W'(c);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0; stalls = 0; reads_seen = 0;
    endtask

    task automatic wait_done();
        int n;
        int d0;
        n = 0;
        d0 = done_cnt;
        while (done_cnt == d0 && n < 3000) begin @(posedge clk); #1; n++; end
        if (done_cnt == d0) begin
            check("done_timeout", done_cnt - d0, 1);
        end else begin
            check("path_len", path_len, exp_len);
            check("err", err, exp_err);
            check("ops_left", exp_q.size(), 0);
            check("reads", reads_seen, exp_reads);
            check("latency", done_cyc, 2 * exp_reads + exp_ops + 2 + stalls);
            @(posedge clk);
            #1;
            check("path_len_stable", path_len, exp_len);
        end
    endtask

    task automatic run_trace(input int r, input int c);
        model(r, c);
        launch(r, c);
        wait_done();
    endtask

    task automatic check_reset_outputs();
        check("rst_start_ready", start_ready, 1);
        check("rst_ptr_rd_en", ptr_rd_en, 0);
        check("rst_op_valid", op_valid, 0);
        check("rst_op_code", op_code, 2'd0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_path_len", path_len, 0);
        check("rst_ptr_row", ptr_row, 0);
        check("rst_ptr_col", ptr_col, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        int d0;
        reset = 1'b0; start = 1'b0; start_row = '0; start_col = '0;
        ptr_data = 3'd0; op_ready = 1'b1; ready_mode = 0;
        cyc = 0; done_cnt = 0; done_cyc = 0; stalls = 0; reads_seen = 0;
        #3;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // diagonal run
        fill_mem(3'b111);
        mem[3][3] = 3'd3; mem[2][2] = 3'd3; mem[1][1] = 3'd3;
        run_trace(3, 3);
        check("diag_done_cycle", done_cyc, 11);
        check("diag_len", path_len, 3);

        // mixed path; unread cells hold an illegal code
        fill_mem(3'd5);
        mem[4][2] = 3'd1; mem[3][2] = 3'd3; mem[2][1] = 3'd2;
        run_trace(4, 2);

        // backpressure on the first EMIT
        fill_mem(3'b111);
        mem[3][3] = 3'd3; mem[2][2] = 3'd3; mem[1][1] = 3'd3;
        model(3, 3);
        op_ready = 1'b0;
        launch(3, 3);
        n = 0;
        while (!op_valid && n < 50) begin @(posedge clk); #1; n++; end
        check("bp_op_valid_seen", op_valid, 1);
        repeat (5) begin @(posedge clk); #1; end
        op_ready = 1'b1;
        wait_done();
        check("bp_stalls", stalls, 5);

        // STOP at start, illegal at start, illegal after one op
        fill_mem(3'b111);
        run_trace(10, 20);
        mem[10][20] = 3'd5;
        run_trace(10, 20);
        mem[3][5] = 3'd3; mem[2][4] = 3'd5;
        run_trace(3, 5);

        // boundary cells
        mem[0][5] = 3'd1;
        run_trace(0, 5);
        mem[7][0] = 3'd2;
        run_trace(7, 0);
        mem[0][0] = 3'd3;
        run_trace(0, 0);

        // saturation (and err cleared by a new start)
        fill_mem(3'd3);
        run_trace(40, 40);

        // start pulsed while busy
        fill_mem(3'd5);
        mem[4][2] = 3'd1; mem[3][2] = 3'd3; mem[2][1] = 3'd2;
        model(4, 2);
        launch(4, 2);
        repeat (3) begin @(posedge clk); #1; end
        start_row = 6'd1; start_col = 6'd1; start = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        start = 1'b0;
        wait_done();

        // reset during the second WAIT
        fill_mem(3'd3);
        model(3, 3);
        launch(3, 3);
        repeat (4) begin @(posedge clk); #1; end
        check("pre_reset_in_wait", dbg_state == ST_WAIT, 1);
        check("pre_reset_len", path_len, 1);
        d0 = done_cnt;
        reset = 1'b0;
        #1;
        check_reset_outputs();
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check("no_done_after_reset", done_cnt, d0);
        check("idle_after_reset", start_ready, 1);
        run_trace(3, 3);

        // randomized traces
        for (int t = 0; t < 30; t++) begin
            fill_random();
            ready_mode = t % 2;
            if (ready_mode == 0) op_ready = 1'b1;
            run_trace($urandom_range(0, 63), $urandom_range(0, 63));
        end
        ready_mode = 0;
        op_ready = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/traceback_engine.md
TRACEBACK_ENGINE -- requirements
Module: traceback_engine

Interface
REQ-001 The block SHALL take parameter ADDR_W, default 6, as the width of the row and column indices into the direction-pointer memory (64x64 cells).
REQ-002 The block SHALL take parameter LEN_W, default ADDR_W+1, as the width of the path-length counter.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Port start, input, 1: request a traceback from the start cell.
REQ-006 Port start_row / start_col, input, ADDR_W each: the max-score cell where traceback begins.
REQ-007 Port start_ready, output, 1: high only in IDLE.
REQ-008 Port ptr_rd_en, output, 1: pointer-memory read strobe.
REQ-009 Port ptr_row / ptr_col, output, ADDR_W each: pointer-memory read address.
REQ-010 Port ptr_data, input, 3: pointer code, valid exactly one cycle after ptr_rd_en.
REQ-011 Port op_valid, output, 1, with op_code, output, 2: alignment-op stream (DIAG=2'd0, UP=2'd1, LEFT=2'd2).
REQ-012 Port op_ready, input, 1: downstream accept for the op stream.
REQ-013 Port done, output, 1: one-cycle pulse at the end of a traceback.
REQ-014 Port path_len, output, LEN_W: number of ops emitted; stable from done until the next accepted start.
REQ-015 Port err, output, 1: sticky flag set on an illegal pointer code; cleared on the next accepted start.

Function
REQ-016 Pointer codes SHALL be: 3'd1 = UP (row-1), 3'd2 = LEFT (col-1), 3'd3 = DIAG (row-1, col-1), 3'b111 = STOP (zero score); all other codes are illegal.
REQ-017 The FSM SHALL use states IDLE, READ, WAIT, EMIT and FIN.
REQ-018 IDLE->READ SHALL occur on start=1; cur_row/cur_col load from start_row/start_col, path_len clears to 0 and err clears.
REQ-019 In IDLE, start SHALL be the only accepted event.
REQ-020 In READ, the block SHALL assert ptr_rd_en for exactly one cycle with ptr_row/ptr_col = cur_row/cur_col, then go to WAIT.
REQ-021 In WAIT, the block SHALL register ptr_data.
REQ-022 WAIT SHALL go to FIN on STOP, or on an illegal code (also setting err).
REQ-023 WAIT SHALL go to EMIT on UP, LEFT or DIAG, driving the matching op_code.
REQ-024 In EMIT, op_valid SHALL stay high and op_code stable until op_ready=1.
REQ-025 On the EMIT handshake cycle the block SHALL update cur_row/cur_col per REQ-016 and increment path_len.
REQ-026 After the EMIT handshake, the next state SHALL be FIN if the move leaves row=0 or col=0, else READ.
REQ-027 A move from row 0 or col 0 SHALL never occur: such a pointer at a boundary cell is treated as STOP and sets err.
REQ-028 path_len SHALL saturate at all-ones and never wrap.
REQ-029 FIN SHALL assert done for one cycle and return to IDLE; start_ready returns high on the following cycle.
REQ-030 Latency per step with op_ready tied high SHALL be 3 cycles (READ, WAIT, EMIT); a path of N ops from start acceptance to the done pulse takes 3N+2 cycles.
REQ-031 start asserted outside IDLE SHALL be ignored with no state change.
REQ-032 ptr_rd_en SHALL never be high in any state other than READ.

Reset
REQ-033 Asserting reset (low) SHALL asynchronously force IDLE and clear op_valid, ptr_rd_en, done, err, path_len, cur_row, cur_col, ptr_row and ptr_col.
REQ-034 After reset, op_code SHALL be DIAG and start_ready SHALL be 1.
REQ-035 Reset mid-traceback SHALL drop any pending op without a handshake and produce no done pulse.

Structure
REQ-036 The pointer codes, op codes and FSM state enum SHALL live in the shared package sw_pkg, which the PE array also uses for its pointer outputs.
REQ-037 The block SHALL be a single module with no sub-modules; the pointer memory is external.

Verification
REQ-038 Diagonal run: start (3,3), memory returns DIAG at (3,3),(2,2),(1,1), op_ready=1 -> three DIAG ops, done at cycle 11 after acceptance, path_len=3, err=0.
REQ-039 Mixed path: start (4,2), pointers UP@(4,2), DIAG@(3,2), LEFT@(2,1), STOP@(2,0 not read; col=0) -> ops UP, DIAG, LEFT, then done, path_len=3.
REQ-040 Backpressure: hold op_ready=0 for 5 cycles during the first EMIT -> op_valid held, op_code stable, no ptr_rd_en, addresses unchanged; completes normally after release.
REQ-041 STOP and illegal codes: STOP at the start cell -> done with path_len=0, no op_valid; code 3'd5 -> done, err=1, path_len unchanged.
REQ-042 start pulsed while busy, and reset (low) asserted during WAIT -> start ignored; after reset, IDLE with all outputs zero, no done pulse, and a new start accepted normally.
REQ-043 The bench SHALL check REQ-032 (ptr_rd_en only in READ) and REQ-024 (op stable while op_valid and not op_ready) as assertions throughout all scenarios.
